seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 2500: clock cycles per digit slot; legal range >= BLANK_CYC+1.
REQ-002 SHALL have parameter BLANK_CYC, default 8: anti-ghost blank cycles at the start of each slot; legal range >= 1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock, the only clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wr_valid  in  1  digit-write request.
REQ-007 wr_ready  out  1  write may be accepted this cycle.
REQ-008 wr_digit  in  2  target digit index, 0..3.
REQ-009 wr_value  in  4  hex value, 0x0..0xF.
REQ-010 wr_dp  in  1  decimal point for that digit.
REQ-011 wr_blank  in  1  digit is dark (overrides value and dp).
REQ-012 bright  in  3  brightness; 7 = full on.
REQ-013 seg  out  7  active-high segments, bit0 = a .. bit6 = g.
REQ-014 dp  out  1  active-high decimal point.
REQ-015 dig_en  out  4  one-hot active-high digit enable.
REQ-016 frame_tick  out  1  one-cycle pulse per completed 4-digit frame.

Function
REQ-017 SHALL hold a 4-entry shadow buffer and a 4-entry active buffer; each entry = {blank, dp, value}.
REQ-018 A write is accepted on a rising edge with wr_valid && wr_ready; the shadow entry wr_digit is updated at that edge.
REQ-019 Consecutive writes to the same digit: the last accepted write wins.
REQ-020 Counters: slot_cnt 0..SCAN_DIV-1 and cur_dig 0..3; slot_cnt increments every cycle and wraps to 0 at SCAN_DIV-1, at which point cur_dig increments modulo 4 (scan order 0,1,2,3,0).
REQ-021 Commit cycle = slot_cnt==SCAN_DIV-1 && cur_dig==3; on that edge all four shadow entries SHALL be copied to the active buffer (tear-free update).
REQ-022 wr_ready SHALL be 0 during the commit cycle and 1 in every other cycle; a held request is accepted the following cycle.
REQ-023 A write accepted mid-frame SHALL NOT alter the display until the next commit, including writes to the digit currently shown.
REQ-024 Phase: slot_cnt < BLANK_CYC is BLANK; otherwise ON with pwm = (slot_cnt - BLANK_CYC) modulo 8.
REQ-025 Lit condition: phase ON, pwm <= bright, and active entry cur_dig not blank.
REQ-026 When lit, the block SHALL output seg = hex pattern of the value, dp = entry dp and dig_en = one-hot(cur_dig); when not lit, seg, dp and dig_en SHALL all be 0.
REQ-027 Hex patterns (g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-028 seg, dp, dig_en and frame_tick SHALL be registered, one cycle latency after the counter state that produced them.
REQ-029 frame_tick SHALL be 1 for exactly the cycle after the commit edge.
REQ-030 bright is sampled every cycle; a change takes effect on the next cycle's registered output.

Reset
REQ-031 While rst_n=0 the block SHALL force immediately: seg=0, dp=0, dig_en=0, frame_tick=0, slot_cnt=0, cur_dig=0, all shadow and active entries blank=1, dp=0, value=0.
REQ-032 wr_ready SHALL be 1 during reset and 1 in the first cycle after release.
REQ-033 Reset asserted mid-slot or mid-frame discards all pending shadow writes.

Structure
REQ-034 Package seg_pkg SHALL hold the digit-entry struct typedef, NUM_DIGITS=4 and the 16-entry hex segment table constants.
REQ-035 Sub-module seg_hex_decode (combinational, 4-bit value to 7-bit seg) SHALL be instantiated once.

Verification (SCAN_DIV=16, BLANK_CYC=4, bright=7 unless noted)
REQ-036 Reset hold then release, no writes -> seg/dp/dig_en stay 0 for 2 frames; frame_tick pulses every 64 cycles; wr_ready low only 1 cycle in 64.
REQ-037 Write digit0=0x3, digit2=0xA with dp=1 -> after the next frame_tick, slot0 shows seg=0x4F, dig_en=0001 for 12 cycles after 4 blank cycles; slot2 shows seg=0x77, dp=1, dig_en=0100; slots 1 and 3 stay dark.
REQ-038 bright=1, digit0=0x8 -> within slot0 the ON-phase offsets 0,1,8,9 are lit (seg=0x7F) and all other cycles are dark.
REQ-039 wr_valid held across the commit cycle -> wr_ready=0 on that cycle; the write is accepted the next cycle and becomes visible one frame later, not in the current frame.
REQ-040 Write digit1=0x5 then digit1=0xC mid-frame -> the current frame is unchanged and the next frame shows seg=0x39 on digit1.
REQ-041 rst_n pulsed low mid-ON-slot -> outputs go 0 asynchronously and all digits are dark after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment scanner.
// Holds the digit-entry layout and the hex glyph table.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 2;
    localparam int PWM_W      = 3;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] value;
    } seg_entry_t;

    localparam seg_entry_t ENTRY_RST = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

    // Index 0 is the rightmost element; segments are {g,f,e,d,c,b,a}.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [NUM_DIGITS-1:0] dig_onehot(
        input logic [DIG_W-1:0] dig
    );
        dig_onehot = NUM_DIGITS'(1) << dig;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex value to seven-segment glyph lookup.
// Pure table read; no state.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered digits,
// anti-ghost blanking and 3-bit PWM brightness.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 2500,
    parameter int BLANK_CYC = 8
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [3:0] wr_value,
    input  logic       wr_dp,
    input  logic       wr_blank,
    input  logic [2:0] bright,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig_en,
    output logic       frame_tick
);

    localparam int SW_RAW = $clog2(SCAN_DIV);
    localparam int SW     = (SW_RAW > PWM_W) ? SW_RAW : PWM_W;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [SW-1:0]    r_slot_cnt;
    logic [DIG_W-1:0] r_cur_dig;
    seg_entry_t       r_shadow [NUM_DIGITS];
    seg_entry_t       r_active [NUM_DIGITS];

    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_dig_en;
    logic             r_frame_tick;

    logic             w_slot_last;
    logic             w_commit;
    logic             w_wr_fire;
    logic             w_on;
    logic [PWM_W-1:0] w_pwm;
    logic             w_lit;
    seg_entry_t       w_cur;
    logic [6:0]       w_seg;
    seg_entry_t       w_wr_entry;

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_commit    = w_slot_last && (r_cur_dig == DIG_LAST);
    assign wr_ready    = !w_commit;
    assign w_wr_fire   = wr_valid && wr_ready;

    assign w_wr_entry = '{blank: wr_blank, dp: wr_dp, value: wr_value};

    assign w_cur = r_active[r_cur_dig];
    assign w_on  = (r_slot_cnt >= BLANK_END);
    assign w_pwm = PWM_W'(r_slot_cnt - BLANK_END);
    assign w_lit = w_on && (w_pwm <= bright) && !w_cur.blank;

    seg_hex_decode u_hex (
        .i_value (w_cur.value),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_cur_dig  <= '0;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_cur_dig  <= r_cur_dig + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Writes only touch the shadow copy; the display follows at the frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= ENTRY_RST;
                r_active[i] <= ENTRY_RST;
            end
        end else begin
            if (w_wr_fire) begin
                r_shadow[wr_digit] <= w_wr_entry;
            end
            if (w_commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_dig_en     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_commit;
            if (w_lit) begin
                r_seg    <= w_seg;
                r_dp     <= w_cur.dp;
                r_dig_en <= dig_onehot(r_cur_dig);
            end else begin
                r_seg    <= '0;
                r_dp     <= 1'b0;
                r_dig_en <= '0;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign dig_en     = r_dig_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count based
// reference model of the scan, double buffer and PWM rules.
module tb_seg_scan_ctrl;

    localparam int SD    = 16;
    localparam int BC    = 4;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_digit = '0;
    logic [3:0] wr_value = '0;
    logic       wr_dp = 1'b0;
    logic       wr_blank = 1'b0;
    logic [2:0] bright = 3'd7;
    logic       wr_ready;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;
    logic       frame_tick;

    seg_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_digit   (wr_digit),
        .wr_value   (wr_value),
        .wr_dp      (wr_dp),
        .wr_blank   (wr_blank),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;

    int glyph [16] = '{
        'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71
    };

    int sh_val [4];
    bit sh_dp  [4];
    bit sh_bl  [4];
    int ac_val [4];
    bit ac_dp  [4];
    bit ac_bl  [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 4; i++) begin
            sh_val[i] = 0; sh_dp[i] = 0; sh_bl[i] = 1;
            ac_val[i] = 0; ac_dp[i] = 0; ac_bl[i] = 1;
        end
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_seg"}, 32'(seg), 0);
        chk({tag, "_dp"}, 32'(dp), 0);
        chk({tag, "_en"}, 32'(dig_en), 0);
        chk({tag, "_tick"}, 32'(frame_tick), 0);
        chk({tag, "_rdy"}, 32'(wr_ready), 1);
    endtask

    task automatic cycle(input bit v, input int d, input int val,
                         input bit p, input bit b);
        int  slot, dg, e_seg, e_dp, e_en;
        bit  commit, lit;
        wr_valid = v;
        wr_digit = 2'(d);
        wr_value = 4'(val);
        wr_dp    = p;
        wr_blank = b;
        #1;
        slot   = t % SD;
        dg     = (t / SD) % 4;
        commit = (t % FRAME) == FRAME - 1;
        chk("wr_ready", 32'(wr_ready), 32'(!commit));
        lit   = slot >= BC && ((slot - BC) % 8) <= int'(bright) && !ac_bl[dg];
        e_seg = lit ? glyph[ac_val[dg]] : 0;
        e_dp  = lit ? int'(ac_dp[dg]) : 0;
        e_en  = lit ? (1 << dg) : 0;
        @(posedge clk);
        if (v && !commit) begin
            sh_val[d] = val; sh_dp[d] = p; sh_bl[d] = b;
        end
        if (commit) begin
            ac_val = sh_val; ac_dp = sh_dp; ac_bl = sh_bl;
        end
        t++;
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("dig_en", 32'(dig_en), 32'(e_en));
        chk("frame_tick", 32'(frame_tick), 32'(commit));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic idle_to(input int pos);
        while ((t % FRAME) != pos) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse(input string tag);
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_dark(tag);
        @(posedge clk);
        #1;
        check_dark(tag);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        check_dark("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_dark("rst_hold");
        rst_n = 1'b1;

        idle(2 * FRAME);

        cycle(1, 0, 'h3, 0, 0);
        cycle(1, 2, 'hA, 1, 0);
        idle(2 * FRAME);

        bright = 3'd1;
        cycle(1, 0, 'h8, 0, 0);
        idle(2 * FRAME);
        bright = 3'd7;

        idle_to(FRAME - 2);
        repeat (3) cycle(1, 3, 'h5, 0, 0);
        idle(2 * FRAME);

        idle_to(10);
        cycle(1, 1, 'h5, 0, 0);
        cycle(1, 1, 'hC, 0, 0);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(49) == 0) bright = 3'($urandom_range(7));
            cycle($urandom_range(3) == 0, int'($urandom_range(3)),
                  int'($urandom_range(15)), 1'($urandom_range(1)),
                  $urandom_range(4) == 0);
        end

        bright = 3'd7;
        for (int i = 0; i < 4; i++) cycle(1, i, 'h8 + i, 1, 0);
        idle(FRAME);
        idle_to(SD + BC + 4);
        cycle(1, 0, 'h1, 0, 0);
        chk("lit_before_rst", 32'(dig_en), 32'h2);
        reset_pulse("mid_rst");
        idle(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
